ble_cmd_auth: RTL and testbench

//  Receives 8N1 serial bytes from the BLE module on RX and runs the rider

---
 rtl/ble_cmd_auth.sv | 148 ++++++++++++++
 tb/tb_ble_cmd_auth.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ble_cmd_auth.sv
// BLE command receiver: 8N1 UART RX plus rider authorization FSM.
// 'g' powers the balance controller up; 's' stops it once the rider is off.
module ble_cmd_auth #(
  parameter int         BAUD_DIV = 2604,
  parameter logic [7:0] CMD_GO   = 8'h67,
  parameter logic [7:0] CMD_STOP = 8'h73
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);

  localparam int CLG = $clog2(BAUD_DIV + 1);
  localparam int CW  = (CLG > 12) ? CLG : 12;

  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_HI
  } rx_st_t;

  typedef enum logic [1:0] {
    A_OFF,
    A_PWR1,
    A_PWR2
  } auth_st_t;

  rx_st_t     rx_st;
  auth_st_t   auth_st;
  logic       rx_s1;
  logic       rx_s2;
  logic       rx_s3;
  logic       start_edge;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       is_go;
  logic       is_stop;

  assign start_edge = rx_s3 & ~rx_s2;
  assign is_go      = rx_rdy && (rx_data == CMD_GO);
  assign is_stop    = rx_rdy && (rx_data == CMD_STOP);

  // RX synchronizer, bit timing and byte assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_st     <= R_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= RX;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_st)
        R_IDLE: begin
          if (start_edge) begin
            cnt   <= HALF;
            rx_st <= R_START;
          end
        end
        R_START: begin
          if (cnt == '0) begin
            if (rx_s2) begin
              rx_st <= R_IDLE;
            end else begin
              cnt     <= FULL;
              bit_cnt <= '0;
              rx_st   <= R_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == '0) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= FULL;
            if (bit_cnt == 3'd7) rx_st <= R_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == '0) begin
            if (rx_s2) begin
              rx_data <= shreg;
              rx_rdy  <= 1'b1;
              rx_st   <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_st     <= R_WAIT_HI;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_WAIT_HI: begin
          if (rx_s2) rx_st <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Rider authorization; pwr_up lags the state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_st <= A_OFF;
      pwr_up  <= 1'b0;
    end else begin
      pwr_up <= (auth_st != A_OFF);
      unique case (auth_st)
        A_OFF: begin
          if (is_go) auth_st <= A_PWR1;
        end
        A_PWR1: begin
          if (is_stop) auth_st <= rider_off ? A_OFF : A_PWR2;
        end
        A_PWR2: begin
          if (rider_off)  auth_st <= A_OFF;
          else if (is_go) auth_st <= A_PWR1;
        end
        default: auth_st <= A_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_cmd_auth.sv
// Directed bench for ble_cmd_auth at a shortened baud divisor.
// Frames are driven bit by bit; a monitor counts pulses and timing.
module tb_ble_cmd_auth;

  localparam int BAUD = 32;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       pwr_up;

  int vectors;
  int miscompares;
  int cyc;
  int rdy_cnt;
  int fe_cnt;
  int rdy_cyc;
  int pwr_chg_cyc;
  logic       pwr_prev;
  logic [7:0] last_data;
  int rdy0;
  int fe0;

  ble_cmd_auth #(.BAUD_DIV(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err),
    .pwr_up    (pwr_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and edge timestamps, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_rdy === 1'b1) begin
      rdy_cnt   = rdy_cnt + 1;
      rdy_cyc   = cyc;
      last_data = rx_data;
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (pwr_up !== pwr_prev) begin
      pwr_chg_cyc = cyc;
      pwr_prev    = pwr_up;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout observed, finish required");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    RX = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rdy_cnt     = 0;
    fe_cnt      = 0;
    rdy_cyc     = 0;
    pwr_chg_cyc = 0;
    pwr_prev    = 1'b0;
    last_data   = 8'h00;
    rst_n       = 1'b0;
    RX          = 1'b1;
    rider_off   = 1'b0;

    idle(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_pwr_up", {31'd0, pwr_up}, 32'd0);
    rst_n = 1'b1;
    idle(BAUD);

    // 1: go command powers up two cycles after rx_rdy
    send_byte(8'h67);
    check("t1_rdy_cnt", rdy_cnt, 1);
    check("t1_data", {24'd0, last_data}, 32'h67);
    check("t1_rx_data", {24'd0, rx_data}, 32'h67);
    check("t1_pwr_up", {31'd0, pwr_up}, 32'd1);
    check("t1_pwr_lat", pwr_chg_cyc - rdy_cyc, 2);

    // 2: stop with rider on holds power until rider steps off
    send_byte(8'h73);
    check("t2_rdy_cnt", rdy_cnt, 2);
    check("t2_pwr_hold", {31'd0, pwr_up}, 32'd1);
    @(posedge clk); #1;
    rider_off = 1'b1;
    idle(2);
    check("t2_pwr_off", {31'd0, pwr_up}, 32'd0);

    // 3: rider_off alone keeps PWR1; stop with rider off drops power
    rider_off = 1'b0;
    send_byte(8'h67);
    check("t3_pwr_on", {31'd0, pwr_up}, 32'd1);
    rider_off = 1'b1;
    idle(20);
    check("t3_pwr1_hold", {31'd0, pwr_up}, 32'd1);
    send_byte(8'h73);
    check("t3_pwr_off", {31'd0, pwr_up}, 32'd0);
    check("t3_off_lat", pwr_chg_cyc - rdy_cyc, 2);
    send_byte(8'h41);
    check("t3_rdy_cnt", rdy_cnt, 5);
    check("t3_data41", {24'd0, last_data}, 32'h41);
    check("t3_pwr_stay", {31'd0, pwr_up}, 32'd0);
    rider_off = 1'b0;

    // 4: short low glitch is rejected
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    RX = 1'b0;
    repeat (BAUD / 4) @(posedge clk);
    #1;
    RX = 1'b1;
    idle(3 * BAUD);
    check("t4_no_rdy", rdy_cnt, rdy0);
    check("t4_no_fe", fe_cnt, fe0);
    send_byte(8'h67);
    check("t4_data", {24'd0, last_data}, 32'h67);
    check("t4_rdy_cnt", rdy_cnt, rdy0 + 1);

    // power down again so the break test ends with a real power-up
    rider_off = 1'b1;
    send_byte(8'h73);
    check("t5_pre_off", {31'd0, pwr_up}, 32'd0);
    rider_off = 1'b0;

    // 5: break gives exactly one frame error and no byte
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    RX = 1'b0;
    repeat (12 * BAUD) @(posedge clk);
    #1;
    RX = 1'b1;
    idle(BAUD);
    check("t5_fe_cnt", fe_cnt, fe0 + 1);
    check("t5_no_rdy", rdy_cnt, rdy0);
    send_byte(8'h67);
    check("t5_data", {24'd0, last_data}, 32'h67);
    check("t5_pwr_up", {31'd0, pwr_up}, 32'd1);

    // 6: reset during bit 4 drops the partial byte
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0] | (i < 3));
    RX = 1'b0;
    repeat (BAUD / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    RX    = 1'b1;
    @(negedge clk);
    check("t6_rx_data", {24'd0, rx_data}, 32'h00);
    check("t6_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    check("t6_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_pwr_up", {31'd0, pwr_up}, 32'd0);
    rdy0 = rdy_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(11 * BAUD);
    check("t6_no_rdy", rdy_cnt, rdy0);
    check("t6_pwr_stay", {31'd0, pwr_up}, 32'd0);
    send_byte(8'h67);
    check("t6_data", {24'd0, last_data}, 32'h67);
    check("t6_pwr_up_after", {31'd0, pwr_up}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
